// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pkg
// Purpose  : Shared constants and types for the loadable instruction memory.
//            Holds the opcode fields used to build the default fill word and
//            the loader state encoding.
// Contents : OP_ADDI, OP_JUMP     - 4-bit opcode fields
//            FILL_INSTR_DEFAULT   - JUMP 1, returned for out-of-range fetches
//            ld_state_e           - loader FSM states
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

  localparam logic [3:0]  OP_ADDI = 4'h3;
  localparam logic [3:0]  OP_JUMP = 4'hF;

  // JUMP 1: bounces a runaway PC back to the start of the program.
  localparam logic [15:0] FILL_INSTR_DEFAULT = {OP_JUMP, 12'h001};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/sp_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_1r1w
// Purpose  : DEPTH x DATA_W storage with one registered read port and one
//            synchronous write port. Power-up contents: word 0 = 0, every
//            other word = FILL. Reset clears only the read register.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            re, raddr, rdata  - read enable, address, registered read data
//            we, waddr, wdata  - write enable, address, write data
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_1r1w #(
  parameter int              DATA_W = 16,
  parameter int              DEPTH  = 256,
  parameter int              AW     = 8,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] words [DEPTH];

  // One register per word so each can carry its own power-up value; word 0
  // holds the interrupt vector (0), the rest hold the fill instruction.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [DATA_W-1:0] INIT = (i == 0) ? '0 : FILL;
    logic [DATA_W-1:0] word = INIT;

    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(i))) begin
        word <= wdata;
      end
    end

    assign words[i] = word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= words[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loadable
// Purpose  : DEPTH-word synchronous instruction memory fetched by PC and
//            reprogrammable at run time from a byte stream. Bytes are packed
//            big-endian into DATA_W words and written from ld_base upward.
//            Fetch is only served while the loader is idle.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            PC, fetch_en             - fetch address and request
//            INSTR, instr_valid       - fetched word, one-cycle valid
//            ld_start, ld_base        - start a load at word address ld_base
//            ld_byte, ld_valid,
//            ld_last, ld_ready        - byte stream handshake
//            ld_busy, ld_done, ld_err - load status
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 256,
  parameter logic [DATA_W-1:0] FILL_INSTR = DATA_W'(FILL_INSTR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] INSTR,
  output logic              instr_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int BPW    = DATA_W / 8;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(BPW + 1);

  // DEPTH may equal 2**ADDR_W, so range checks use one extra bit.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  ld_state_e         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] asm_word;
  logic              last_word;
  logic              pc_oor;
  logic              err;

  logic              pc_in_range;
  logic              ptr_in_range;
  logic              fetch_go;
  logic [DATA_W+7:0] shifted;
  logic [CNT_W-1:0]  pad_bytes;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] ram_rdata;

  assign pc_in_range  = {1'b0, PC} < DEPTH_LIM;
  assign ptr_in_range = {1'b0, wr_ptr} < DEPTH_LIM;
  assign fetch_go     = (state == IDLE) && fetch_en;

  // First byte ends up in the MS position after BPW shifts.
  assign shifted   = {asm_word, ld_byte};
  // A short final word holds its bytes in the low end; slide them up so the
  // missing low bytes read as zero.
  assign pad_bytes = CNT_W'(BPW) - byte_cnt;
  assign wr_word   = asm_word << {pad_bytes, 3'b000};

  sp_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW),
    .FILL   (FILL_INSTR)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (fetch_go && pc_in_range),
    .raddr (PC[RAM_AW-1:0]),
    .rdata (ram_rdata),
    .we    ((state == WRITE) && ptr_in_range),
    .waddr (wr_ptr[RAM_AW-1:0]),
    .wdata (wr_word)
  );

  // Both the RAM read register and pc_oor only update on a fetch, so INSTR
  // holds between fetches and reads 0 after reset.
  assign INSTR    = pc_oor ? FILL_INSTR : ram_rdata;
  assign ld_ready = (state == LOAD);
  assign ld_busy  = (state == LOAD) || (state == WRITE);
  assign ld_done  = (state == DONE);
  assign ld_err   = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      byte_cnt    <= '0;
      asm_word    <= '0;
      last_word   <= 1'b0;
      err         <= 1'b0;
      pc_oor      <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_go;
      if (fetch_go) begin
        pc_oor <= !pc_in_range;
      end

      case (state)
        IDLE: begin
          if (ld_start) begin
            wr_ptr   <= ld_base;
            byte_cnt <= '0;
            asm_word <= '0;
            err      <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            asm_word  <= shifted[DATA_W-1:0];
            byte_cnt  <= byte_cnt + CNT_W'(1);
            last_word <= ld_last;
            if (ld_last || (byte_cnt == CNT_W'(BPW - 1))) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!ptr_in_range) begin
            err <= 1'b1;
          end
          wr_ptr   <= wr_ptr + ADDR_W'(1);
          byte_cnt <= '0;
          asm_word <= '0;
          state    <= last_word ? DONE : LOAD;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loadable
// Purpose  : Self-checking bench for instr_mem_loadable. Fetch expectations
//            are queued when a fetch is driven and compared when instr_valid
//            appears; loader status is checked inline per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC;
  logic        fetch_en;
  logic [15:0] INSTR;
  logic        instr_valid;
  logic        ld_start;
  logic [15:0] ld_base;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  logic [7:0]  ld_bytes [$];
  int          pulses;

  always #5 clk = ~clk;

  instr_mem_loadable #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .DEPTH      (256),
    .FILL_INSTR (16'hF001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .fetch_en    (fetch_en),
    .INSTR       (INSTR),
    .instr_valid (instr_valid),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_byte     (ld_byte),
    .ld_valid    (ld_valid),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done),
    .ld_err      (ld_err)
  );

  // Scoreboard consumer: every instr_valid must match the oldest queued fetch.
  always @(negedge clk) begin
    if (rst !== 1'b1 && instr_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fetch_unexpected: instr_valid=1 INSTR=%h, no fetch outstanding", INSTR);
      end else begin
        mon_exp = exp_q.pop_front();
        if (INSTR !== mon_exp) begin
          bad++;
          $display("FAIL fetch_data: INSTR=%h expected=%h", INSTR, mon_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] e);
    fetch_en = 1'b1;
    PC       = pc;
    exp_q.push_back(e);
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: %0d fetches without instr_valid, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int w;
    w = 0;
    while (ld_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL ld_ready_timeout: ld_ready=%b expected 1", ld_ready);
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Drives the bytes in ld_bytes as one image, then counts ld_done pulses.
  task automatic run_load(input logic [15:0] base, input int max_gap,
                          input bit mid_start, input bit fetch_at_start,
                          input bit fetch_during);
    int n;
    int gap;
    n = ld_bytes.size();
    ld_start = 1'b1;
    ld_base  = base;
    if (fetch_at_start) begin
      // Fetch and start together: the fetch is served, loading follows.
      fetch_en = 1'b1;
      PC       = 16'd2;
      exp_q.push_back(16'hF001);
    end
    @(negedge clk);
    ld_start = 1'b0;
    fetch_en = 1'b0;
    if (fetch_during) begin
      fetch_en = 1'b1;
      PC       = 16'd16;
    end
    for (int k = 0; k < n; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      if (mid_start && k == 1) begin
        ld_start = 1'b1;
        ld_base  = 16'd40;
        @(negedge clk);
        ld_start = 1'b0;
      end
      send_byte(ld_bytes[k], k == n - 1);
    end
    fetch_en = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (ld_done === 1'b1) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL ld_done_pulses: got=%0d expected=1 (base=%h)", pulses, base);
    end
    total++;
    if (ld_busy !== 1'b0) begin
      bad++;
      $display("FAIL ld_busy_after_load: ld_busy=%b expected 0", ld_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; PC = '0; fetch_en = 1'b0; ld_start = 1'b0; ld_base = '0;
    ld_byte = '0; ld_valid = 1'b0; ld_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 8'h55;
    @(negedge clk);
    total++; if (INSTR !== 16'h0000) begin bad++; $display("FAIL reset_instr: INSTR=%h expected 0000", INSTR); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got=%b expected 0", instr_valid); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready: got=%b expected 0", ld_ready); end
    total++; if (ld_busy !== 1'b0) begin bad++; $display("FAIL reset_ld_busy: got=%b expected 0", ld_busy); end
    total++; if (ld_done !== 1'b0) begin bad++; $display("FAIL reset_ld_done: got=%b expected 0", ld_done); end
    total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL reset_ld_err: got=%b expected 0", ld_err); end
    ld_valid = 1'b0;
  endtask

  task automatic test_fetch_init();
    do_fetch(16'd0,   16'h0000);
    do_fetch(16'd1,   16'hF001);
    do_fetch(16'd300, 16'hF001);
    drain("fetch_init");
  endtask

  task automatic test_load_basic();
    ld_bytes = '{8'h30, 8'h12, 8'h31, 8'h21};
    run_load(16'd1, 0, 1'b0, 1'b1, 1'b0);
    total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL basic_ld_err: got=%b expected 0", ld_err); end
    do_fetch(16'd1, 16'h3012);
    do_fetch(16'd2, 16'h3121);
    drain("load_basic");
  endtask

  task automatic test_load_short();
    ld_bytes = '{8'h3A, 8'hBC, 8'h7F};
    run_load(16'd4, 0, 1'b0, 1'b0, 1'b0);
    do_fetch(16'd4, 16'h3ABC);
    do_fetch(16'd5, 16'h7F00);
    drain("load_short");
  endtask

  task automatic test_back_to_back_gaps();
    ld_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    run_load(16'd16, 0, 1'b0, 1'b0, 1'b0);
    run_load(16'd20, 3, 1'b1, 1'b0, 1'b1);
    do_fetch(16'd16, 16'hA1B2);
    do_fetch(16'd17, 16'hC3D4);
    do_fetch(16'd18, 16'hE5F6);
    do_fetch(16'd20, 16'hA1B2);
    do_fetch(16'd21, 16'hC3D4);
    do_fetch(16'd22, 16'hE5F6);
    do_fetch(16'd40, 16'hF001);
    drain("load_gaps");
  endtask

  task automatic test_overflow();
    ld_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(16'd255, 0, 1'b0, 1'b0, 1'b0);
    total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL overflow_ld_err: got=%b expected 1", ld_err); end
    do_fetch(16'd255, 16'hAABB);
    do_fetch(16'd256, 16'hF001);
    do_fetch(16'd0,   16'h0000);
    drain("overflow");
  endtask

  task automatic test_rst_midload();
    do_fetch(16'd5, 16'h7F00);
    drain("pre_rst");
    ld_start = 1'b1;
    ld_base  = 16'd8;
    @(negedge clk);
    ld_start = 1'b0;
    total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL start_clears_err: ld_err=%b expected 0", ld_err); end
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (ld_busy !== 1'b0) begin bad++; $display("FAIL rst_ld_busy: got=%b expected 0", ld_busy); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready: got=%b expected 0", ld_ready); end
    total++; if (INSTR !== 16'h0000) begin bad++; $display("FAIL rst_instr: INSTR=%h expected 0000", INSTR); end
    total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL rst_ld_err: got=%b expected 0", ld_err); end
    do_fetch(16'd8, 16'h1122);
    do_fetch(16'd9, 16'hF001);
    do_fetch(16'd4, 16'h3ABC);
    drain("rst_midload");
  endtask

  initial begin
    test_reset();
    test_fetch_init();
    test_load_basic();
    test_load_short();
    test_back_to_back_gaps();
    test_overflow();
    test_rst_midload();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised successor to the fixed-contents instruction ROM: a DEPTH-word synchronous instruction memory.
- It is fetched by the CPU via PC and can be reprogrammed at run time through a byte-stream loader (valid/ready handshake, e.g. from a UART).
- It sits between the fetch stage and the program-download path.
- Out-of-range fetches return FILL_INSTR, a jump back to the program start, as before.

Parameters:
- DATA_W, 16, instruction width in bits; must be a multiple of 8.
- ADDR_W, 16, width of PC and ld_base.
- DEPTH, 256, number of instruction words implemented; must be ≤ 2**ADDR_W.
- FILL_INSTR, 16'hF001, word returned for PC ≥ DEPTH and used as the power-up fill (JUMP 1).
- Derived localparam BPW = DATA_W/8, the number of bytes per word.

Ports:
- clk, input, 1, system clock; all logic acts on its rising edge.
- rst, input, 1, synchronous active-high reset.
- PC, input, ADDR_W, fetch address.
- fetch_en, input, 1, fetch request.
- INSTR, output, DATA_W, registered fetched instruction.
- instr_valid, output, 1, high for one cycle when INSTR was updated by a fetch.
- ld_start, input, 1, begin an image load at ld_base.
- ld_base, input, ADDR_W, first word address of the load.
- ld_byte, input, 8, loader data byte.
- ld_valid, input, 1, ld_byte is valid.
- ld_last, input, 1, qualifies ld_byte as the final byte of the image.
- ld_ready, output, 1, block accepts ld_byte this cycle.
- ld_busy, output, 1, a load is in progress; fetch is blocked.
- ld_done, output, 1, one-cycle pulse when a load completes.
- ld_err, output, 1, sticky flag: at least one word of the current or last load addressed ≥ DEPTH.

Behaviour:
- Reset values:
  - INSTR = 0 (the interrupt vector word).
  - instr_valid = 0, ld_ready = 0, ld_busy = 0, ld_done = 0, ld_err = 0.
  - FSM in IDLE; byte counter = 0; write pointer = 0.
  - Memory contents are not cleared by reset.
- Power-up init (initial fill): word 0 = 0; all other words = FILL_INSTR.
- Fetch:
  - Fetch operates only in IDLE, with a latency of 1 cycle.
  - When fetch_en = 1, INSTR <= (PC < DEPTH) ? mem[PC] : FILL_INSTR, and instr_valid <= 1.
  - When fetch_en = 0, or in any non-IDLE state, INSTR holds its value and instr_valid <= 0.
- FSM states:
  - IDLE:
    - ld_ready = 0.
    - On ld_start: write pointer <= ld_base, byte counter <= 0, ld_err <= 0, go to LOAD.
    - If ld_start and fetch_en are asserted in the same cycle, the fetch completes (INSTR updates, instr_valid = 1) and LOAD is entered the next cycle.
  - LOAD:
    - ld_ready = 1 and ld_busy = 1.
    - Each handshake (ld_valid & ld_ready) shifts ld_byte into the assembly register, big-endian (first byte = MS byte), and increments the byte counter.
    - After BPW bytes, or on a byte with ld_last = 1, go to WRITE.
  - WRITE:
    - Duration is exactly one cycle; ld_ready = 0 and ld_busy = 1.
    - On a short final word, the unfilled low bytes are 0.
    - If the write pointer < DEPTH, mem[pointer] <= word; otherwise the write is suppressed and ld_err <= 1.
    - The pointer increments with an ADDR_W wrap and the byte counter clears.
    - If the word ended with ld_last, go to DONE; otherwise go to LOAD.
  - DONE: ld_done = 1 for one cycle, ld_busy = 0, then go to IDLE.
- Boundary conditions:
  - ld_start while not in IDLE is ignored.
  - ld_valid in IDLE or DONE is not accepted, because ld_ready = 0.
  - ld_valid = 0 in LOAD stalls indefinitely with no timeout.
  - Write-pointer wrap past 2**ADDR_W-1 goes to 0; address 0 is written if 0 < DEPTH.
  - rst mid-load:
    - FSM returns to IDLE and the partial word is discarded.
    - Words already written remain in memory.
    - ld_err clears.
  - Because fetch is blocked during a load, no read-during-write hazard exists. A fetch in the cycle after DONE returns the newly written data.

Decomposition:
- Package instr_mem_pkg holds:
  - opcode constants: OP_ADDI = 4'h3, OP_JUMP = 4'hF;
  - a default FILL_INSTR value;
  - FSM state enum {IDLE, LOAD, WRITE, DONE}.
- One sub-module, sp_ram_1r1w: a DEPTH × DATA_W array with a registered read port, a synchronous write port and the init fill.
- The FSM, byte assembler and out-of-range mux live in the top module.

Test Plan:
- Reset, then fetch_en = 1 with PC = 0, 1, 300 → INSTR = 0000, F001, F001, each with instr_valid high one cycle after its PC.
- Load with ld_base = 1, bytes 30 12 31 21 (last on 21), then fetch PC = 1 and PC = 2 → INSTR = 3012, then 3121. ld_done pulses once and ld_err = 0.
- Load with ld_base = 4, bytes 3A, BC, 7F (last on 7F) → mem[4] = 3ABC, mem[5] = 7F00.
- ld_valid toggled with 0–3 idle cycles between bytes, plus ld_start asserted again mid-load → data identical to the gap-free load and the second ld_start is ignored.
- Load with ld_base = 255 and 4 bytes, DEPTH = 256 → mem[255] written, second word suppressed, ld_err = 1 after DONE, fetch of PC = 256 returns F001.
- Assert rst after 3 bytes of a 6-byte load → FSM IDLE, ld_busy = 0, mem[base] updated, mem[base+1] unchanged, INSTR = 0, ld_err = 0.
